// File: rtl/output_result_div.sv
// rtl/output_result_div.sv - pipelined radix-2 restoring divider with rounding, saturation and div-zero flag
module output_result_div #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 20,
    parameter int QUOT_W     = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  StartIn,
    input  logic [DIVIDEND_W-1:0] DataIn,
    input  logic [DIVISOR_W-1:0]  Divisor,
    input  logic                  RoundIn,
    output logic                  StartOut,
    output logic [QUOT_W-1:0]     DataOut,
    output logic                  SatOut,
    output logic                  DivZeroOut
);

    localparam int NS = DIVIDEND_W;

    // dq holds the not-yet-consumed dividend bits in the top and the quotient bits shifted in below
    logic [NS-1:0]         valid_q;
    logic [DIVIDEND_W-1:0] dq_q    [NS];
    logic [DIVIDEND_W-1:0] dq_d    [NS];
    logic [DIVISOR_W-1:0]  rem_q   [NS];
    logic [DIVISOR_W-1:0]  rem_d   [NS];
    logic [DIVISOR_W-1:0]  dvs_q   [NS];
    logic [NS-1:0]         round_q;
    logic [NS-1:0]         dz_q;

    logic [DIVIDEND_W-1:0] src_dq  [NS];
    logic [DIVISOR_W-1:0]  src_rem [NS];
    logic [DIVISOR_W-1:0]  src_dvs [NS];

    always_comb begin
        src_dq[0]  = DataIn;
        src_rem[0] = '0;
        src_dvs[0] = Divisor;
        for (int i = 1; i < NS; i++) begin
            src_dq[i]  = dq_q[i-1];
            src_rem[i] = rem_q[i-1];
            src_dvs[i] = dvs_q[i-1];
        end
    end

    always_comb begin
        logic [DIVISOR_W:0] trial;
        logic               qbit;
        trial = '0;
        qbit  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            trial = {src_rem[i], src_dq[i][DIVIDEND_W-1]};
            qbit  = (trial >= {1'b0, src_dvs[i]});
            // the true difference is below the divisor, so DIVISOR_W-bit wraparound arithmetic is exact
            rem_d[i] = qbit ? (trial[DIVISOR_W-1:0] - src_dvs[i]) : trial[DIVISOR_W-1:0];
            dq_d[i]  = {src_dq[i][DIVIDEND_W-2:0], qbit};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[NS-2:0], StartIn};
        end
    end

    always_ff @(posedge clock) begin
        dq_q    <= dq_d;
        rem_q   <= rem_d;
        dvs_q   <= src_dvs;
        round_q <= {round_q[NS-2:0], RoundIn};
        dz_q    <= {dz_q[NS-2:0], (Divisor == '0)};
    end

    logic                  round_up;
    logic [DIVIDEND_W:0]   q_rnd;
    logic                  sat;
    logic [QUOT_W-1:0]     data_out_d;
    logic                  sat_out_d;
    logic                  dz_out_d;

    always_comb begin
        round_up = round_q[NS-1] && ({1'b0, rem_q[NS-1], 1'b0} >= {2'b00, dvs_q[NS-1]});
        q_rnd    = {1'b0, dq_q[NS-1]} + {{DIVIDEND_W{1'b0}}, round_up};
        sat      = |q_rnd[DIVIDEND_W:QUOT_W];
        if (dz_q[NS-1]) begin
            data_out_d = '1;
            sat_out_d  = 1'b0;
            dz_out_d   = 1'b1;
        end else if (sat) begin
            data_out_d = '1;
            sat_out_d  = 1'b1;
            dz_out_d   = 1'b0;
        end else begin
            data_out_d = q_rnd[QUOT_W-1:0];
            sat_out_d  = 1'b0;
            dz_out_d   = 1'b0;
        end
    end

    logic              start_out_q;
    logic [QUOT_W-1:0] data_out_q;
    logic              sat_out_q;
    logic              dz_out_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_out_q <= 1'b0;
            data_out_q  <= '0;
            sat_out_q   <= 1'b0;
            dz_out_q    <= 1'b0;
        end else begin
            start_out_q <= valid_q[NS-1];
            if (valid_q[NS-1]) begin
                data_out_q <= data_out_d;
                sat_out_q  <= sat_out_d;
                dz_out_q   <= dz_out_d;
            end
        end
    end

    assign StartOut   = start_out_q;
    assign DataOut    = data_out_q;
    assign SatOut     = sat_out_q;
    assign DivZeroOut = dz_out_q;

endmodule

// File: doc/output_result_div.md
# output_result_div

Parametrised, fully pipelined unsigned divider for the output stage. Each accepted sample computes DataIn / Divisor and presents the quotient as a QUOT_W-bit result. Rounding can be selected per sample, and the result saturates when it does not fit. Divide-by-zero is flagged rather than producing garbage. Sits at the end of the output pipeline, replacing the fixed 28/20/8 divide stage. Accepts one sample per clock with fixed latency and no stalls.

## Interface
- DIVIDEND_W, 28: width of DataIn (unsigned).
- DIVISOR_W, 20: width of Divisor (unsigned).
- QUOT_W, 8: width of DataOut; must satisfy QUOT_W <= DIVIDEND_W.
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- StartIn  in  1  sample-valid qualifier; DataIn/Divisor/RoundIn are sampled only when high.
- DataIn  in  DIVIDEND_W  dividend.
- Divisor  in  DIVISOR_W  divisor.
- RoundIn  in  1  0 = truncate, 1 = round half up; carried per sample.
- StartOut  out  1  result-valid pulse, one cycle per accepted sample.
- DataOut  out  QUOT_W  quotient, rounded/saturated.
- SatOut  out  1  result clamped to 2^QUOT_W-1 (valid with StartOut).
- DivZeroOut  out  1  Divisor was 0 for this sample (valid with StartOut).

## Operation
- Radix-2 restoring division, one quotient bit per stage, DIVIDEND_W stages, MSB first.
- Stage i: partial remainder R (DIVISOR_W+1 bits) = {R, dividend bit}; if R >= divisor, subtract and set quotient bit, else keep R.
- Each stage registers: valid, remaining dividend bits, quotient bits so far, remainder, divisor, round flag, div-zero flag.
- Div-zero flag = (Divisor == 0), computed at input and carried; the arithmetic result is ignored for that sample.
- Final stage (output register) performs the following:
  - Round: if RoundIn and 2*R >= Divisor, Q = Q + 1. The compare is done at DIVISOR_W+2 bits, with no overflow.
  - Saturate: if Q > 2^QUOT_W-1 (upper DIVIDEND_W-QUOT_W+1 bits of the rounded value nonzero), DataOut = all ones and SatOut = 1.
  - Div-zero: DataOut = all ones, DivZeroOut = 1, SatOut = 0.
  - Otherwise DataOut = Q[QUOT_W-1:0], SatOut = 0, DivZeroOut = 0.
- Samples with StartIn low occupy a bubble: the valid bit is 0 and the datapath contents are don't-care. DataOut/flags hold their last value while StartOut is 0.
- No backpressure; every accepted sample emerges exactly once, in order.

## Timing
- Latency L = DIVIDEND_W + 1 cycles (29 at defaults). StartIn high at edge t gives StartOut high in the cycle after edge t+L-1, i.e. visible for cycle t+L.
- Throughput: 1 sample/cycle; back-to-back StartIn produces back-to-back StartOut with identical spacing.
- Reset (reset_n low, any time) takes effect asynchronously:
  - All valid bits are cleared.
  - StartOut, SatOut and DivZeroOut go to 0; DataOut goes to 0.
  - Samples in flight are discarded and never emitted.
- Reset release: the first StartIn sampled on the first rising edge with reset_n high is accepted normally.
- Datapath registers need not be reset; valid bits and all outputs must be.

## Test plan
- DataIn=1000, Divisor=4, RoundIn=0, single StartIn pulse -> StartOut exactly 29 cycles later, DataOut=250, SatOut=0, DivZeroOut=0.
- DataIn=1022, Divisor=4: RoundIn=0 -> DataOut=255, SatOut=0. Same inputs with RoundIn=1 (255.5 -> 256) -> DataOut=255, SatOut=1.
- DataIn=10, Divisor=4, RoundIn=1 -> 3 (2.5 rounds up). DataIn=9, Divisor=4, RoundIn=1 -> 2 (2.25). DataIn=0xFFFFFFF, Divisor=0xFFFFF, RoundIn=0 -> 256 -> DataOut=255, SatOut=1.
- DataIn=100, Divisor=0 -> DataOut=255, DivZeroOut=1, SatOut=0. The next sample 100/5 -> DataOut=20, flags 0.
- 64 back-to-back random samples with random bubbles in StartIn -> StartOut pattern equals the StartIn pattern delayed by 29; every result matches a reference model, including rounding and saturation.
- Assert reset_n low for 1 cycle while 10 samples are in flight -> all outputs 0 immediately, no StartOut for those samples. A new sample issued after release emerges 29 cycles later, correct.
